div_pipe_unit: RTL and testbench
================================

Name: div_pipe_unit

Overview:
- 8-stage pipelined 32-bit integer divider for DIV/DIVU/REM/REMU.
- Accepts one operation per cycle from the execute stage. Returns each result exactly 8 cycles later on the divider-result interface of the writeback stage: div_valid, div_get_rem, div_dst, div_quotient, div_remainder.
- Exports early-warning and in-flight destination information so hazard logic can stall dependent instructions and schedule the writeback port.

Parameters:
- XLEN, 32, operand/result width.
- STAGES, 8, pipeline depth. Each stage retires XLEN/STAGES = 4 quotient bits.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- div_start  input  1  issue a divide op this cycle.
- div_a  input  32  dividend (rs1).
- div_b  input  32  divisor (rs2).
- div_signed  input  1  1 = DIV/REM, 0 = DIVU/REMU.
- div_rem_in  input  1  1 = REM/REMU requested.
- div_dst_in  input  5  destination register.
- div_valid  output  1  result present this cycle; one-cycle pulse per op.
- div_get_rem  output  1  remainder is the requested result.
- div_dst  output  5  destination register of the result.
- div_quotient  output  32  final quotient.
- div_remainder  output  32  final remainder.
- div_valid_next  output  1  an op will be on the outputs next cycle (stage-8 input valid).
- pending_dst  output  32  bit r set if any op in flight targets xr; bit 0 always 0.

Behaviour:
- Reset: all stage valid bits clear. All outputs 0, including pending_dst and div_valid_next. Asserting rst mid-operation discards every in-flight op; no result is ever emitted for them.
- Issue: div_start is sampled at the rising edge ending cycle c. The result appears in cycle c+8 (div_valid=1 for exactly that cycle).
- Throughput: one op per cycle, no back-pressure, no stall input. Back-to-back issues in cycles c, c+1 produce results in c+8, c+9.
- Stage registers carry: valid, signed flag, rem flag, dst, quotient-negate flag, remainder-negate flag, partial remainder (33b), shifting dividend/quotient (32b), divisor magnitude (32b).
- Stage 1 (combinational from inputs):
  - Compute magnitudes: |a| = a[31]&signed ? -a : a; likewise |b|.
  - q_neg = signed & (a[31]^b[31]) & (b!=0).
  - r_neg = signed & a[31].
  - Perform the first 4 restoring steps.
- Each stage performs 4 restoring steps MSB-first:
  - rem = {rem, next dividend bit};
  - if rem >= divisor: rem -= divisor, qbit = 1; else qbit = 0.
- Output register (stage 8):
  - div_quotient = q_neg ? -q : q.
  - div_remainder = r_neg ? -r : r.
- Divide by zero falls out naturally: q = 0xFFFFFFFF, r = |a|, with q_neg forced 0. Required results:
  - DIV/DIVU: quotient 0xFFFFFFFF.
  - REM/REMU: remainder = a (original signed value).
- Signed overflow (0x80000000 / 0xFFFFFFFF, signed): quotient 0x80000000, remainder 0.
- dst = 0: the op flows through normally and div_valid still pulses; writeback/register file ignores x0. The pending_dst bit is never set for x0.
- div_quotient and div_remainder are both always driven. div_get_rem only selects which one writeback writes.
- pending_dst is the OR over stages 1..8 of onehot(dst) & valid. It is registered-state derived, so combinational from flops. It is not updated for the op issuing in the current cycle; hazard logic compares div_dst_in itself.
- div_valid_next = stage-7 valid. Hazard logic uses it to stall a main-pipe write colliding with the divider's writeback priority.
- Outputs hold their last data when div_valid=0; consumers qualify everything with div_valid.

Test Plan:
- DIVU 100/7 issued in cycle 5 -> cycle 13: div_valid=1, quotient 14, remainder 2, get_rem=0; cycles 12 and 14: div_valid=0.
- DIV -7/2, then REM -7/2, then DIV 7/-2 back-to-back -> three consecutive valid cycles:
  - quotient 0xFFFFFFFD (-3);
  - remainder 0xFFFFFFFF (-1), get_rem=1;
  - quotient 0xFFFFFFFD.
- Divide by zero: DIVU 5/0 -> quotient 0xFFFFFFFF. REM -9/0 -> remainder 0xFFFFFFF7. DIV -9/0 -> quotient 0xFFFFFFFF.
- Overflow: DIV 0x80000000/0xFFFFFFFF -> quotient 0x80000000. REM same operands -> remainder 0.
- Ops issued to x3, x0, x3 in consecutive cycles -> pending_dst = 0x8 while any x3 op is in flight, bit 0 never set. div_valid_next high one cycle before each div_valid.
- rst asserted asynchronously mid-cycle with 4 ops in flight -> outputs and pending_dst drop to 0 immediately. No div_valid pulse follows. An op issued after reset release returns correctly 8 cycles later.

Source files
------------

// File: rtl/div_pipe_unit_if.sv
// Issue/result bundle between the execute stage, the pipelined divider and writeback.
// The master side issues ops and consumes results; the slave side is the divider.
interface div_pipe_unit_if #(
  parameter int XLEN = 32
);
  logic            div_start;
  logic [XLEN-1:0] div_a;
  logic [XLEN-1:0] div_b;
  logic            div_signed;
  logic            div_rem_in;
  logic [4:0]      div_dst_in;

  logic            div_valid;
  logic            div_get_rem;
  logic [4:0]      div_dst;
  logic [XLEN-1:0] div_quotient;
  logic [XLEN-1:0] div_remainder;
  logic            div_valid_next;
  logic [31:0]     pending_dst;

  modport master (
    output div_start, div_a, div_b, div_signed, div_rem_in, div_dst_in,
    input  div_valid, div_get_rem, div_dst, div_quotient, div_remainder,
           div_valid_next, pending_dst
  );

  modport slave (
    input  div_start, div_a, div_b, div_signed, div_rem_in, div_dst_in,
    output div_valid, div_get_rem, div_dst, div_quotient, div_remainder,
           div_valid_next, pending_dst
  );
endinterface

// File: rtl/div_pipe_unit.sv
// Fully pipelined restoring divider: one op per cycle, result exactly STAGES cycles later.
// Each stage retires XLEN/STAGES quotient bits; the last stage also applies the sign fix-up.
module div_pipe_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 8
) (
  input  logic           clk,
  input  logic           rst,
  div_pipe_unit_if.slave bus
);

  localparam int STEPS = XLEN / STAGES;

  typedef struct packed {
    logic            valid;
    logic            sgn;
    logic            rem;
    logic [4:0]      dst;
    logic            q_neg;
    logic            r_neg;
    logic [XLEN:0]   prem;
    logic [XLEN-1:0] dq;
    logic [XLEN-1:0] dvs;
  } stage_t;

  // dq shifts the dividend out of its top while quotient bits enter at the bottom,
  // so after all stages it holds the unsigned quotient and prem the remainder.
  function automatic stage_t retire(input stage_t s);
    stage_t        o;
    logic [XLEN:0] sh;
    o = s;
    for (int i = 0; i < STEPS; i++) begin
      sh   = {o.prem[XLEN-1:0], o.dq[XLEN-1]};
      o.dq = {o.dq[XLEN-2:0], 1'b0};
      if (sh >= {1'b0, o.dvs}) begin
        o.prem  = sh - {1'b0, o.dvs};
        o.dq[0] = 1'b1;
      end else begin
        o.prem = sh;
      end
    end
    return o;
  endfunction

  stage_t          stage_in;
  stage_t          step_out [1:STAGES];
  stage_t          stg_reg  [1:STAGES-1];
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;

  logic            valid_reg;
  logic            get_rem_reg;
  logic [4:0]      dst_reg;
  logic [XLEN-1:0] quotient_reg;
  logic [XLEN-1:0] remainder_reg;
  logic [31:0]     pending_next;

  always_comb begin
    a_mag = (bus.div_a[XLEN-1] & bus.div_signed) ? -bus.div_a : bus.div_a;
    b_mag = (bus.div_b[XLEN-1] & bus.div_signed) ? -bus.div_b : bus.div_b;

    stage_in       = '0;
    stage_in.valid = bus.div_start;
    stage_in.sgn   = bus.div_signed;
    stage_in.rem   = bus.div_rem_in;
    stage_in.dst   = bus.div_dst_in;
    // A zero divisor already yields an all-ones magnitude quotient; never negate it.
    stage_in.q_neg = bus.div_signed & (bus.div_a[XLEN-1] ^ bus.div_b[XLEN-1]) & (bus.div_b != '0);
    stage_in.r_neg = bus.div_signed & bus.div_a[XLEN-1];
    stage_in.dq    = a_mag;
    stage_in.dvs   = b_mag;
  end

  generate
    for (genvar gi = 1; gi <= STAGES; gi++) begin : g_step
      if (gi == 1) begin : g_first
        assign step_out[gi] = retire(stage_in);
      end else begin : g_next
        assign step_out[gi] = retire(stg_reg[gi-1]);
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= STAGES-1; k++) begin
        stg_reg[k] <= '0;
      end
      valid_reg     <= 1'b0;
      get_rem_reg   <= 1'b0;
      dst_reg       <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      for (int k = 1; k <= STAGES-1; k++) begin
        stg_reg[k] <= step_out[k];
      end
      valid_reg <= step_out[STAGES].valid;
      // Result fields hold their last value between ops; consumers qualify with div_valid.
      if (step_out[STAGES].valid) begin
        get_rem_reg   <= step_out[STAGES].rem;
        dst_reg       <= step_out[STAGES].dst;
        quotient_reg  <= step_out[STAGES].q_neg ? -step_out[STAGES].dq : step_out[STAGES].dq;
        remainder_reg <= step_out[STAGES].r_neg ? -step_out[STAGES].prem[XLEN-1:0]
                                                : step_out[STAGES].prem[XLEN-1:0];
      end
    end
  end

  always_comb begin
    pending_next = '0;
    for (int k = 1; k <= STAGES-1; k++) begin
      if (stg_reg[k].valid) begin
        pending_next = pending_next | (32'(1) << stg_reg[k].dst);
      end
    end
    if (valid_reg) begin
      pending_next = pending_next | (32'(1) << dst_reg);
    end
    pending_next[0] = 1'b0;
  end

  assign bus.div_valid      = valid_reg;
  assign bus.div_get_rem    = get_rem_reg;
  assign bus.div_dst        = dst_reg;
  assign bus.div_quotient   = quotient_reg;
  assign bus.div_remainder  = remainder_reg;
  assign bus.div_valid_next = stg_reg[STAGES-1].valid;
  assign bus.pending_dst    = pending_next;

endmodule

// File: tb/tb_div_pipe_unit.sv
// Self-checking bench for div_pipe_unit: directed corner cases plus randomized ops
// compared against a plain-arithmetic RISC-V division model.
module tb_div_pipe_unit;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  div_pipe_unit_if #(.XLEN(32)) bus ();

  div_pipe_unit #(.XLEN(32), .STAGES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          due;
    logic [31:0] q;
    logic [31:0] r;
    logic        gr;
    logic [4:0]  d;
  } exp_t;

  // RISC-V M-extension semantics from plain arithmetic.
  function automatic void model(input logic [31:0] a, input logic [31:0] b, input logic sg,
                                output logic [31:0] q, output logic [31:0] r);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sg && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else if (sg) begin
      q = 32'(sa / sb);
      r = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'($urandom_range(0, 20));
      5:       return 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic set_op(input logic st, input logic [31:0] a, input logic [31:0] b,
                        input logic sg, input logic rm, input logic [4:0] d);
    bus.div_start  = st;
    bus.div_a      = a;
    bus.div_b      = b;
    bus.div_signed = sg;
    bus.div_rem_in = rm;
    bus.div_dst_in = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
    rst = 1'b1;
    tick();
    tick();
    checks += 7;
    if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.div_valid); end
    if (bus.div_valid_next !== 1'b0) begin errors++; $display("FAIL reset_valid_next got=%b want=0", bus.div_valid_next); end
    if (bus.pending_dst !== 32'd0) begin errors++; $display("FAIL reset_pending got=%h want=0", bus.pending_dst); end
    if (bus.div_quotient !== 32'd0) begin errors++; $display("FAIL reset_quotient got=%h want=0", bus.div_quotient); end
    if (bus.div_remainder !== 32'd0) begin errors++; $display("FAIL reset_remainder got=%h want=0", bus.div_remainder); end
    if (bus.div_dst !== 5'd0) begin errors++; $display("FAIL reset_dst got=%0d want=0", bus.div_dst); end
    if (bus.div_get_rem !== 1'b0) begin errors++; $display("FAIL reset_get_rem got=%b want=0", bus.div_get_rem); end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  // DIVU 100/7 issued on tick 1 must appear on tick 8 only.
  task automatic test_basic();
    for (int k = 1; k <= 9; k++) begin
      if (k == 1) set_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, 5'd4);
      else        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
      checks += 2;
      if (bus.div_valid !== (k == 8)) begin errors++; $display("FAIL basic_valid tick=%0d got=%b want=%b", k, bus.div_valid, (k == 8)); end
      if (bus.div_valid_next !== (k == 7)) begin errors++; $display("FAIL basic_valid_next tick=%0d got=%b want=%b", k, bus.div_valid_next, (k == 7)); end
      if (k == 8) begin
        checks += 4;
        if (bus.div_quotient !== 32'd14) begin errors++; $display("FAIL basic_quotient got=%0d want=14", bus.div_quotient); end
        if (bus.div_remainder !== 32'd2) begin errors++; $display("FAIL basic_remainder got=%0d want=2", bus.div_remainder); end
        if (bus.div_get_rem !== 1'b0) begin errors++; $display("FAIL basic_get_rem got=%b want=0", bus.div_get_rem); end
        if (bus.div_dst !== 5'd4) begin errors++; $display("FAIL basic_dst got=%0d want=4", bus.div_dst); end
      end
    end
    $display("test_basic done: DIVU 100/7 -> q=%0d r=%0d", 14, 2);
  endtask

  task automatic test_back_to_back();
    logic [31:0] oa [3];
    logic [31:0] ob [3];
    logic        rm [3];
    logic [31:0] eq [3];
    logic [31:0] er [3];
    oa = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7};
    ob = '{32'd2, 32'd2, 32'hFFFF_FFFE};
    rm = '{1'b0, 1'b1, 1'b0};
    eq = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFD};
    er = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1};
    for (int k = 1; k <= 12; k++) begin
      int j;
      if (k <= 3) set_op(1'b1, oa[k-1], ob[k-1], 1'b1, rm[k-1], 5'(k + 10));
      else        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
      j = k - 8;
      checks++;
      if (bus.div_valid !== (j >= 0 && j <= 2)) begin errors++; $display("FAIL b2b_valid tick=%0d got=%b", k, bus.div_valid); end
      if (j >= 0 && j <= 2) begin
        checks += 4;
        if (bus.div_quotient !== eq[j]) begin errors++; $display("FAIL b2b_quotient op=%0d got=%h want=%h", j, bus.div_quotient, eq[j]); end
        if (bus.div_remainder !== er[j]) begin errors++; $display("FAIL b2b_remainder op=%0d got=%h want=%h", j, bus.div_remainder, er[j]); end
        if (bus.div_get_rem !== rm[j]) begin errors++; $display("FAIL b2b_get_rem op=%0d got=%b want=%b", j, bus.div_get_rem, rm[j]); end
        if (bus.div_dst !== 5'(j + 11)) begin errors++; $display("FAIL b2b_dst op=%0d got=%0d want=%0d", j, bus.div_dst, j + 11); end
        $display("b2b op=%0d q=%h r=%h get_rem=%b", j, bus.div_quotient, bus.div_remainder, bus.div_get_rem);
      end
    end
  endtask

  // Divide by zero and signed overflow, issued back-to-back.
  task automatic test_corners();
    logic [31:0] oa [5];
    logic [31:0] ob [5];
    logic        sg [5];
    logic        rm [5];
    logic [31:0] eq [5];
    logic [31:0] er [5];
    oa = '{32'd5, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'h8000_0000, 32'h8000_0000};
    ob = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    sg = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    rm = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    eq = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000};
    er = '{32'd5, 32'hFFFF_FFF7, 32'hFFFF_FFF7, 32'd0, 32'd0};
    for (int k = 1; k <= 13; k++) begin
      int j;
      if (k <= 5) set_op(1'b1, oa[k-1], ob[k-1], sg[k-1], rm[k-1], 5'(k + 20));
      else        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
      j = k - 8;
      checks++;
      if (bus.div_valid !== (j >= 0 && j <= 4)) begin errors++; $display("FAIL corner_valid tick=%0d got=%b", k, bus.div_valid); end
      if (j >= 0 && j <= 4) begin
        checks += 3;
        if (bus.div_quotient !== eq[j]) begin errors++; $display("FAIL corner_quotient op=%0d got=%h want=%h", j, bus.div_quotient, eq[j]); end
        if (bus.div_remainder !== er[j]) begin errors++; $display("FAIL corner_remainder op=%0d got=%h want=%h", j, bus.div_remainder, er[j]); end
        if (bus.div_get_rem !== rm[j]) begin errors++; $display("FAIL corner_get_rem op=%0d got=%b want=%b", j, bus.div_get_rem, rm[j]); end
        $display("corner op=%0d a=%h b=%h q=%h r=%h", j, oa[j], ob[j], bus.div_quotient, bus.div_remainder);
      end
    end
  endtask

  // x3, x0, x3 on ticks 1..3; an op issued on tick t is in flight on ticks t..t+7.
  task automatic test_pending();
    logic [4:0] d [3];
    d = '{5'd3, 5'd0, 5'd3};
    for (int k = 1; k <= 12; k++) begin
      logic [31:0] exp_pend;
      logic        exp_v;
      logic        exp_vn;
      if (k <= 3) set_op(1'b1, 32'd100, 32'd7, 1'b0, 1'b0, d[k-1]);
      else        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
      exp_pend = 32'd0;
      exp_v    = 1'b0;
      exp_vn   = 1'b0;
      for (int t = 1; t <= 3; t++) begin
        if (k >= t && k <= t + 7 && d[t-1] != 5'd0) exp_pend[d[t-1]] = 1'b1;
        if (k == t + 7) exp_v = 1'b1;
        if (k == t + 6) exp_vn = 1'b1;
      end
      checks += 3;
      if (bus.pending_dst !== exp_pend) begin errors++; $display("FAIL pending tick=%0d got=%h want=%h", k, bus.pending_dst, exp_pend); end
      if (bus.div_valid !== exp_v) begin errors++; $display("FAIL pending_valid tick=%0d got=%b want=%b", k, bus.div_valid, exp_v); end
      if (bus.div_valid_next !== exp_vn) begin errors++; $display("FAIL pending_valid_next tick=%0d got=%b want=%b", k, bus.div_valid_next, exp_vn); end
      $display("pending tick=%0d pending_dst=%h valid=%b valid_next=%b", k, bus.pending_dst, bus.div_valid, bus.div_valid_next);
    end
  endtask

  task automatic test_async_reset();
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) set_op(1'b1, 32'd50, 32'd3, 1'b0, 1'b0, 5'(k + 4));
      else        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
    end
    checks++;
    if (bus.pending_dst !== 32'h0000_01E0) begin errors++; $display("FAIL arst_pre_pending got=%h want=000001e0", bus.pending_dst); end
    #2 rst = 1'b1;
    #1;
    checks += 5;
    if (bus.pending_dst !== 32'd0) begin errors++; $display("FAIL arst_pending got=%h want=0", bus.pending_dst); end
    if (bus.div_valid_next !== 1'b0) begin errors++; $display("FAIL arst_valid_next got=%b want=0", bus.div_valid_next); end
    if (bus.div_quotient !== 32'd0) begin errors++; $display("FAIL arst_quotient got=%h want=0", bus.div_quotient); end
    if (bus.div_remainder !== 32'd0) begin errors++; $display("FAIL arst_remainder got=%h want=0", bus.div_remainder); end
    if (bus.div_dst !== 5'd0) begin errors++; $display("FAIL arst_dst got=%0d want=0", bus.div_dst); end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL arst_ghost_valid tick=%0d got=%b want=0", k, bus.div_valid); end
    end
    for (int k = 1; k <= 9; k++) begin
      if (k == 1) set_op(1'b1, 32'd200, 32'd9, 1'b0, 1'b1, 5'd9);
      else        set_op(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0);
      tick();
      checks++;
      if (bus.div_valid !== (k == 8)) begin errors++; $display("FAIL arst_post_valid tick=%0d got=%b want=%b", k, bus.div_valid, (k == 8)); end
      if (k == 8) begin
        checks += 4;
        if (bus.div_quotient !== 32'd22) begin errors++; $display("FAIL arst_post_quotient got=%0d want=22", bus.div_quotient); end
        if (bus.div_remainder !== 32'd2) begin errors++; $display("FAIL arst_post_remainder got=%0d want=2", bus.div_remainder); end
        if (bus.div_get_rem !== 1'b1) begin errors++; $display("FAIL arst_post_get_rem got=%b want=1", bus.div_get_rem); end
        if (bus.div_dst !== 5'd9) begin errors++; $display("FAIL arst_post_dst got=%0d want=9", bus.div_dst); end
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    exp_t sb[$];
    int   nops = 0;
    for (int k = 1; k <= 310; k++) begin
      logic        issue;
      logic [31:0] a, b, q, r, exp_pend;
      logic        sg, rm, exp_vn;
      logic [4:0]  d;
      exp_t        e;
      issue = (k <= 300) && ($urandom_range(0, 9) < 7);
      a  = pick();
      b  = pick();
      sg = 1'($urandom_range(0, 1));
      rm = 1'($urandom_range(0, 1));
      d  = 5'($urandom_range(0, 31));
      set_op(issue, a, b, sg, rm, d);
      tick();
      if (issue) begin
        model(a, b, sg, q, r);
        e.due = k + 7;
        e.q   = q;
        e.r   = r;
        e.gr  = rm;
        e.d   = d;
        sb.push_back(e);
        nops++;
      end
      exp_pend = 32'd0;
      exp_vn   = 1'b0;
      foreach (sb[i]) begin
        if (sb[i].d != 5'd0) exp_pend[sb[i].d] = 1'b1;
        if (sb[i].due == k + 1) exp_vn = 1'b1;
      end
      checks += 2;
      if (bus.pending_dst !== exp_pend) begin errors++; $display("FAIL rand_pending tick=%0d got=%h want=%h", k, bus.pending_dst, exp_pend); end
      if (bus.div_valid_next !== exp_vn) begin errors++; $display("FAIL rand_valid_next tick=%0d got=%b want=%b", k, bus.div_valid_next, exp_vn); end
      if (sb.size() > 0 && sb[0].due == k) begin
        e = sb.pop_front();
        checks += 5;
        if (bus.div_valid !== 1'b1) begin errors++; $display("FAIL rand_valid tick=%0d got=%b want=1", k, bus.div_valid); end
        if (bus.div_quotient !== e.q) begin errors++; $display("FAIL rand_quotient tick=%0d got=%h want=%h", k, bus.div_quotient, e.q); end
        if (bus.div_remainder !== e.r) begin errors++; $display("FAIL rand_remainder tick=%0d got=%h want=%h", k, bus.div_remainder, e.r); end
        if (bus.div_get_rem !== e.gr) begin errors++; $display("FAIL rand_get_rem tick=%0d got=%b want=%b", k, bus.div_get_rem, e.gr); end
        if (bus.div_dst !== e.d) begin errors++; $display("FAIL rand_dst tick=%0d got=%0d want=%0d", k, bus.div_dst, e.d); end
        $display("rand tick=%0d dst=%0d q=%h r=%h", k, e.d, e.q, e.r);
      end else begin
        checks++;
        if (bus.div_valid !== 1'b0) begin errors++; $display("FAIL rand_idle_valid tick=%0d got=%b want=0", k, bus.div_valid); end
      end
    end
    $display("test_random done: %0d ops", nops);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_corners();
    test_pending();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
